// File: rtl/pb_pkg.sv
// Shared definitions for the pushbutton conditioner: state encoding and
// default / simulation-sized cycle counts.
package pb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_WAIT = 3'd1,
        ST_PRESSED    = 3'd2,
        ST_REPEAT     = 3'd3,
        ST_REL_WAIT   = 3'd4
    } pb_state_t;

    // 100 MHz defaults: 5 ms debounce, 500 ms hold, 100 ms repeat period
    localparam int DEF_DB   = 500000;
    localparam int DEF_HOLD = 50000000;
    localparam int DEF_REP  = 10000000;

    localparam int SIM_DB   = 4;
    localparam int SIM_HOLD = 10;
    localparam int SIM_REP  = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make both flops sample on the same edge;
    // blocking ones would collapse the chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pb_conditioner.sv
// Pushbutton front end: synchronize, debounce, emit press/release strobes,
// optional hold-to-repeat, and keep a wrapping count of press strobes.
module pb_conditioner
    import pb_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB,
    parameter int HOLD_CYCLES   = DEF_HOLD,
    parameter int REPEAT_CYCLES = DEF_REP,
    parameter int REPEAT_EN     = 1
) (
    input  logic       clk100MHz,
    input  logic       rst,
    input  logic       pb,
    output logic       pb_level,
    output logic       pb_pulse,
    output logic       rel_pulse,
    output logic [7:0] press_cnt
);

    localparam int CNT_W = $clog2(max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             sync_q;
    pb_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_d, pulse_d, rel_d;
    logic [7:0]       press_cnt_d;

    sync2 u_sync (
        .clk   (clk100MHz),
        .rst_n (rst),
        .d     (pb),
        .q     (sync_q)
    );

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = pb_level;
        pulse_d = 1'b0;
        rel_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                level_d = 1'b0;
                if (sync_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                level_d = 1'b0;
                if (!sync_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_PRESSED;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                level_d = 1'b1;
                if (!sync_q) begin
                    state_d = ST_REL_WAIT;
                    cnt_d   = CNT_ONE;
                end else if (REPEAT_EN != 0 && cnt_q == HOLD_LAST) begin
                    state_d = ST_REPEAT;
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q != HOLD_LAST) begin
                    // Saturates when repeat is off so a long hold never wraps.
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                level_d = 1'b1;
                if (!sync_q) begin
                    state_d = ST_REL_WAIT;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == REP_LAST) begin
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REL_WAIT: begin
                level_d = 1'b1;
                if (sync_q) begin
                    // A short release drops back to PRESSED, restarting the hold timer.
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase

        press_cnt_d = press_cnt + {7'd0, pulse_d};
    end

    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pb_level  <= 1'b0;
            pb_pulse  <= 1'b0;
            rel_pulse <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pb_level  <= level_d;
            pb_pulse  <= pulse_d;
            rel_pulse <= rel_d;
            press_cnt <= press_cnt_d;
        end
    end

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner using the small simulation cycle counts.
module tb_pb_conditioner;
    import pb_pkg::*;

    logic       clk;
    logic       rst;
    logic       pb;
    logic       lvl_a, pulse_a, rel_a;
    logic [7:0] cnt_a;
    logic       lvl_b, pulse_b, rel_b;
    logic [7:0] cnt_b;

    int tests;
    int fails;

    pb_conditioner #(
        .DB_CYCLES(SIM_DB), .HOLD_CYCLES(SIM_HOLD),
        .REPEAT_CYCLES(SIM_REP), .REPEAT_EN(1)
    ) u_dut (
        .clk100MHz(clk), .rst(rst), .pb(pb),
        .pb_level(lvl_a), .pb_pulse(pulse_a), .rel_pulse(rel_a), .press_cnt(cnt_a)
    );

    pb_conditioner #(
        .DB_CYCLES(SIM_DB), .HOLD_CYCLES(SIM_HOLD),
        .REPEAT_CYCLES(SIM_REP), .REPEAT_EN(0)
    ) u_norep (
        .clk100MHz(clk), .rst(rst), .pb(pb),
        .pb_level(lvl_b), .pb_pulse(pulse_b), .rel_pulse(rel_b), .press_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and park on the following falling edge.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        pb  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pb  = 1'b0;
        #1 rst = 1'b0;
        #1;
        tests++;
        if ({lvl_a, pulse_a, rel_a, cnt_a} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected all zero", {lvl_a, pulse_a, rel_a, cnt_a});
        end
        do_reset();
    endtask

    // Cycle c is the cycle beginning at the c-th edge after pb rises.
    task automatic test_clean_press();
        do_reset();
        pb = 1'b1;
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            tests++;
            if (pulse_a !== (c == 5)) begin
                fails++;
                $display("FAIL clean_pulse cycle %0d: got %b expected %b", c, pulse_a, c == 5);
            end
            tests++;
            if (lvl_a !== (c >= 5)) begin
                fails++;
                $display("FAIL clean_level cycle %0d: got %b expected %b", c, lvl_a, c >= 5);
            end
        end
        tests++;
        if (cnt_a !== 8'd1) begin
            fails++;
            $display("FAIL clean_count: got %0d expected 1", cnt_a);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pattern;
        pattern = 5'b10101;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            pb = (c < 5) ? pattern[4 - c] : 1'b1;
            next_cycle();
            tests++;
            if (pulse_a !== (c == 9)) begin
                fails++;
                $display("FAIL bounce_pulse cycle %0d: got %b expected %b", c, pulse_a, c == 9);
            end
            tests++;
            if (lvl_a !== (c >= 9)) begin
                fails++;
                $display("FAIL bounce_level cycle %0d: got %b expected %b", c, lvl_a, c >= 9);
            end
        end
        tests++;
        if (cnt_a !== 8'd1) begin
            fails++;
            $display("FAIL bounce_count: got %0d expected 1", cnt_a);
        end
    endtask

    // Accept at 5, repeats at 15,18,...,33; pb falls before edge 33 so the
    // release strobe lands at 38.
    task automatic test_auto_repeat();
        logic exp_p;
        do_reset();
        pb = 1'b1;
        for (int c = 0; c < 42; c++) begin
            next_cycle();
            exp_p = (c == 5) || (c >= 15 && c <= 33 && (c - 15) % 3 == 0);
            tests++;
            if (pulse_a !== exp_p) begin
                fails++;
                $display("FAIL repeat_pulse cycle %0d: got %b expected %b", c, pulse_a, exp_p);
            end
            tests++;
            if (rel_a !== (c == 38)) begin
                fails++;
                $display("FAIL repeat_rel cycle %0d: got %b expected %b", c, rel_a, c == 38);
            end
            tests++;
            if (lvl_a !== (c >= 5 && c < 38)) begin
                fails++;
                $display("FAIL repeat_level cycle %0d: got %b expected %b", c, lvl_a, c >= 5 && c < 38);
            end
            if (c == 32) pb = 1'b0;
        end
        tests++;
        if (cnt_a !== 8'd8) begin
            fails++;
            $display("FAIL repeat_count: got %0d expected 8", cnt_a);
        end
    endtask

    task automatic test_no_repeat();
        do_reset();
        pb = 1'b1;
        for (int c = 0; c < 42; c++) begin
            next_cycle();
            tests++;
            if (pulse_b !== (c == 5)) begin
                fails++;
                $display("FAIL norep_pulse cycle %0d: got %b expected %b", c, pulse_b, c == 5);
            end
            tests++;
            if (rel_b !== (c == 38)) begin
                fails++;
                $display("FAIL norep_rel cycle %0d: got %b expected %b", c, rel_b, c == 38);
            end
            if (c == 32) pb = 1'b0;
        end
        tests++;
        if (cnt_b !== 8'd1) begin
            fails++;
            $display("FAIL norep_count: got %0d expected 1", cnt_b);
        end
    endtask

    // pb low before edges 8 and 9 only; the hold timer restarts at 12, so the
    // first repeat moves from 15 to 22.
    task automatic test_release_glitch();
        do_reset();
        pb = 1'b1;
        for (int c = 0; c < 24; c++) begin
            next_cycle();
            tests++;
            if (pulse_a !== (c == 5 || c == 22)) begin
                fails++;
                $display("FAIL glitch_pulse cycle %0d: got %b expected %b", c, pulse_a, c == 5 || c == 22);
            end
            tests++;
            if (rel_a !== 1'b0) begin
                fails++;
                $display("FAIL glitch_rel cycle %0d: got %b expected 0", c, rel_a);
            end
            tests++;
            if (lvl_a !== (c >= 5)) begin
                fails++;
                $display("FAIL glitch_level cycle %0d: got %b expected %b", c, lvl_a, c >= 5);
            end
            pb = (c == 7 || c == 8) ? 1'b0 : 1'b1;
        end
        tests++;
        if (cnt_a !== 8'd2) begin
            fails++;
            $display("FAIL glitch_count: got %0d expected 2", cnt_a);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        pb = 1'b1;
        repeat (21) next_cycle();
        tests++;
        if (cnt_a !== 8'd3 || lvl_a !== 1'b1) begin
            fails++;
            $display("FAIL midrepeat_state: got cnt %0d level %b expected cnt 3 level 1", cnt_a, lvl_a);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({lvl_a, pulse_a, rel_a, cnt_a} !== 11'd0) begin
            fails++;
            $display("FAIL async_reset: got %b expected all zero", {lvl_a, pulse_a, rel_a, cnt_a});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            tests++;
            if (pulse_a !== (c == 5)) begin
                fails++;
                $display("FAIL post_reset_pulse cycle %0d: got %b expected %b", c, pulse_a, c == 5);
            end
        end
        tests++;
        if (cnt_a !== 8'd1) begin
            fails++;
            $display("FAIL post_reset_count: got %0d expected 1", cnt_a);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        for (int p = 0; p < 256; p++) begin
            pb = 1'b1;
            repeat (8) next_cycle();
            pb = 1'b0;
            repeat (8) next_cycle();
            if (p == 254) begin
                tests++;
                if (cnt_a !== 8'hFF) begin
                    fails++;
                    $display("FAIL count_ff: got %0d expected 255", cnt_a);
                end
            end
        end
        tests++;
        if (cnt_a !== 8'h00) begin
            fails++;
            $display("FAIL count_wrap: got %0d expected 0", cnt_a);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_no_repeat();
        test_release_glitch();
        test_async_reset();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pb_conditioner.md
Name: pb_conditioner

Overview:
- Front-end conditioner for a raw board pushbutton.
- Chain: two-flop synchronizer, counter-based debounce, press/release one-shots, optional hold-to-repeat.
- Sits directly upstream of the CALC stepper. Runs on clk100MHz and replaces the slow-clock debounce; CALC advances on pb_pulse as a clock enable instead of using a button-derived clock.
- Also exposes a wrapping press counter for display and diagnostics.

Parameters:
- DB_CYCLES, 500000, consecutive stable synchronized samples required to accept a level change (5 ms at 100 MHz); minimum 2.
- HOLD_CYCLES, 50000000, cycles after press acceptance before the first auto-repeat pulse.
- REPEAT_CYCLES, 10000000, cycles between subsequent auto-repeat pulses.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 gives exactly one pb_pulse per press.
- CNT_W, derived via $clog2 of the largest of the three cycle parameters, plus 1; shared counter width.

Ports:
- clk100MHz  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- pb  input  1  raw asynchronous button, 1 = pressed
- pb_level  output  1  debounced button level
- pb_pulse  output  1  one-cycle strobe on accepted press and on each auto-repeat
- rel_pulse  output  1  one-cycle strobe on accepted release
- press_cnt  output  8  count of pb_pulse strobes, wraps

Behaviour:
Reset:
- rst low at any time, including mid-debounce or mid-repeat, immediately forces the following: state IDLE, both sync flops 0, counters 0, all outputs 0.
- Release of rst is sampled synchronously.

Synchronizer:
- sync1 <= pb; sync_q <= sync1.
- Only sync_q feeds the FSM.

FSM states and transitions:
- IDLE: cnt = 0; pb_level = 0.
  - sync_q = 1 -> PRESS_WAIT, cnt = 1.
- PRESS_WAIT: on sync_q = 1, cnt increments.
  - When cnt = DB_CYCLES-1 and sync_q = 1 -> PRESSED. Register outputs: pb_level = 1, pb_pulse = 1, cnt = 0.
  - sync_q = 0 -> IDLE, cnt = 0, no strobe.
- PRESSED: pb_level = 1; cnt counts held cycles.
  - REPEAT_EN = 1 and cnt = HOLD_CYCLES-1 -> REPEAT, pb_pulse = 1, cnt = 0.
  - sync_q = 0 -> REL_WAIT, cnt = 1.
- REPEAT: pb_level = 1.
  - cnt = REPEAT_CYCLES-1 -> pb_pulse = 1, cnt = 0, remain in REPEAT.
  - sync_q = 0 -> REL_WAIT, cnt = 1.
- REL_WAIT: pb_level stays 1.
  - On sync_q = 0, cnt increments. At cnt = DB_CYCLES-1 -> IDLE, pb_level = 0, rel_pulse = 1.
  - sync_q = 1 -> PRESSED, cnt = 0. No pb_pulse; the hold timer restarts.

Timing and output rules:
- Latency: pb stable high before edge k gives pb_pulse high for exactly one cycle, from edge k+1+DB_CYCLES to edge k+2+DB_CYCLES. Release latency is identical.
- All outputs are registered; no combinational path from pb.
- pb_pulse and rel_pulse are never high in the same cycle. Each lasts exactly one cycle.
- press_cnt increments by 1 in the cycle pb_pulse is high. 8'hFF wraps to 8'h00.
- Glitches shorter than DB_CYCLES synchronized cycles produce no strobe and no pb_level change.
- A release shorter than DB_CYCLES during REPEAT returns to PRESSED (not REPEAT), so repeat restarts after HOLD_CYCLES.

Decomposition:
- Shared package pb_pkg:
  - State encoding constants ST_IDLE, ST_PRESS_WAIT, ST_PRESSED, ST_REPEAT, ST_REL_WAIT (3-bit).
  - Default cycle counts, plus simulation overrides SIM_DB = 4, SIM_HOLD = 10, SIM_REP = 3.
- One sub-module, sync2: a two-flop synchronizer with async active-low reset, reusable for the in1/in2/op/go switches.
- The FSM and counters stay in pb_conditioner.

Test Plan:
All runs use DB_CYCLES = 4, HOLD_CYCLES = 10, REPEAT_CYCLES = 3, REPEAT_EN = 1 unless stated.
1. Clean press: pb rises before edge 10 and is held 8 cycles -> pb_pulse high only in cycle 15, pb_level 1 from cycle 15, press_cnt = 1.
2. Bounce: pb toggles 1,0,1,0 on consecutive cycles, then goes stable high -> no strobe during the bounce, exactly one pb_pulse 5 cycles after the last rise, press_cnt = 1.
3. Auto-repeat: hold pb 30 cycles past acceptance -> pb_pulse at acceptance, then at +10, +13, +16, +19, +22, +25, +28, giving press_cnt = 8. Release -> one rel_pulse 5 cycles after the fall, pb_level = 0.
4. REPEAT_EN = 0, same hold -> exactly one pb_pulse, press_cnt = 1.
5. Release glitch: while PRESSED, pb low for 2 cycles -> no rel_pulse, pb_level stays 1, no new pb_pulse.
6. Async reset mid-repeat: rst low between edges -> all outputs 0 and press_cnt = 0 before the next edge. After rst returns high with pb held, a new press is accepted after 5 cycles.
